fp16_sub_seq: RTL and testbench

Multi-cycle FP16 subtractor, the inverse-direction companion of the team's combinational FP16 adder. It computes o_data = i_data_a − i_data_b, bit-exact with the adder evaluated as add(data_1 = a, data_2 = b with bit 15 inverted). It trades area for latency through serial alignment and normalization shifters, and sits behind a valid/ready handshake on the ALU result path.

---
 rtl/fp16_pkg.sv | 32 +++
 rtl/fp16_round_pack.sv | 41 ++++
 rtl/fp16_sub_seq.sv | 147 ++++++++++++++
 tb/tb_fp16_sub_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 definitions: field slices, extended-mantissa geometry and the
// sequencer state encoding used by the multi-cycle FP16 arithmetic blocks.
package fp16_pkg;

    localparam int FP_W     = 16;
    localparam int E_W      = 5;
    localparam int F_W      = 10;
    localparam int S_BIT    = 15;
    localparam int E_HI     = 14;
    localparam int E_LO     = 10;
    localparam int F_HI     = 9;
    localparam int F_LO     = 0;
    localparam int EXT_W    = 23;
    localparam int NORM_MAX = 20;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_e;

    function automatic logic [E_W-1:0] fp_exp(input logic [FP_W-1:0] x);
        return x[E_HI:E_LO];
    endfunction

    function automatic logic [F_W-1:0] fp_frac(input logic [FP_W-1:0] x);
        return x[F_HI:F_LO];
    endfunction

endpackage

// File: rtl/fp16_round_pack.sv
// Combinational round-and-pack of a normalized extended magnitude into FP16.
// Bit 21 of the magnitude arrives separately as the carry flag c_i.
module fp16_round_pack
    import fp16_pkg::*;
(
    input  logic [EXT_W-3:0] mag_i,
    input  logic             c_i,
    input  logic [4:0]       n_i,
    input  logic             sign_i,
    input  logic [E_W-1:0]   exp_l_i,
    output logic [FP_W-1:0]  data_o
);

    logic           g;
    logic           r;
    logic           s;
    logic           up;
    logic [F_W-1:0] f;
    logic [F_W-1:0] f_out;
    logic [E_W-1:0] e_out;

    always_comb begin
        if (c_i) begin
            g = mag_i[11];
            r = mag_i[10];
            s = |mag_i[9:0];
            f = mag_i[20:11];
        end else begin
            g = mag_i[10];
            r = mag_i[9];
            s = |mag_i[8:0];
            f = mag_i[19:10];
        end
        // Fraction wraps on round-up; the exponent is deliberately not bumped.
        up     = (g & r) | (r & s);
        f_out  = f + {{(F_W-1){1'b0}}, up};
        e_out  = exp_l_i + {{(E_W-1){1'b0}}, c_i} - n_i;
        data_o = {sign_i, e_out, f_out};
    end

endmodule

// File: rtl/fp16_sub_seq.sv
// Multi-cycle FP16 subtractor (a - b) with serial alignment and normalization
// shifters behind a valid/ready handshake.
module fp16_sub_seq #(
    parameter int EXT_W    = 23,
    parameter int NORM_MAX = 20
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [15:0] i_data_a,
    input  logic [15:0] i_data_b,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [15:0] o_data
);
    import fp16_pkg::*;

    state_e           state_q, state_d;
    logic [4:0]       acnt_q, acnt_d;
    logic [4:0]       ncnt_q, ncnt_d;
    logic [FP_W-1:0]  data_q, data_d;
    logic [EXT_W-1:0] ex_l_q, ex_l_d;
    logic [EXT_W-1:0] ex_s_q, ex_s_d;
    logic [EXT_W-1:0] mag_q, mag_d;
    logic             sign_l_q, sign_l_d;
    logic             sign_s_q, sign_s_d;
    logic             sign_q, sign_d;
    logic [E_W-1:0]   exp_l_q, exp_l_d;

    logic [FP_W-1:0]  b_neg;
    logic [FP_W-1:0]  op_l;
    logic [FP_W-1:0]  op_s;
    logic [E_W-1:0]   d_exp;
    logic [4:0]       acnt_ld;
    logic [EXT_W-1:0] add_l;
    logic [EXT_W-1:0] add_s;
    logic [EXT_W-1:0] sum;
    logic [FP_W-1:0]  packed_w;

    // Subtraction is addition of b with its sign flipped; exponent ties pick b'.
    assign b_neg   = {~i_data_b[S_BIT], i_data_b[S_BIT-1:0]};
    assign op_l    = (fp_exp(i_data_a) <= fp_exp(b_neg)) ? b_neg : i_data_a;
    assign op_s    = (fp_exp(i_data_a) <= fp_exp(b_neg)) ? i_data_a : b_neg;
    assign d_exp   = fp_exp(op_l) - fp_exp(op_s);
    assign acnt_ld = (d_exp > 5'(EXT_W)) ? 5'(EXT_W) : d_exp;

    assign add_l = sign_l_q ? -ex_l_q : ex_l_q;
    assign add_s = sign_s_q ? -ex_s_q : ex_s_q;
    assign sum   = add_l + add_s;

    fp16_round_pack u_round_pack (
        .mag_i   (mag_q[EXT_W-3:0]),
        .c_i     (mag_q[EXT_W-2]),
        .n_i     (ncnt_q),
        .sign_i  (sign_q),
        .exp_l_i (exp_l_q),
        .data_o  (packed_w)
    );

    always_comb begin
        state_d  = state_q;
        acnt_d   = acnt_q;
        ncnt_d   = ncnt_q;
        data_d   = data_q;
        ex_l_d   = ex_l_q;
        ex_s_d   = ex_s_q;
        mag_d    = mag_q;
        sign_l_d = sign_l_q;
        sign_s_d = sign_s_q;
        sign_d   = sign_q;
        exp_l_d  = exp_l_q;
        o_ready  = (state_q == IDLE);
        o_valid  = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    ex_l_d   = {3'b001, fp_frac(op_l), 10'b0};
                    ex_s_d   = {3'b001, fp_frac(op_s), 10'b0};
                    sign_l_d = op_l[S_BIT];
                    sign_s_d = op_s[S_BIT];
                    exp_l_d  = fp_exp(op_l);
                    acnt_d   = acnt_ld;
                    ncnt_d   = 5'd0;
                    state_d  = ALIGN;
                end
            end
            ALIGN: begin
                if (acnt_q == 5'd0) begin
                    state_d = ADD;
                end else begin
                    ex_s_d = ex_s_q >> 1;
                    acnt_d = acnt_q - 5'd1;
                end
            end
            ADD: begin
                sign_d  = sum[EXT_W-1];
                mag_d   = sum[EXT_W-1] ? -sum : sum;
                state_d = NORM;
            end
            NORM: begin
                // A carry into bit 21 is taken as-is; otherwise shift until the hidden bit lands.
                if (mag_q[EXT_W-2] || mag_q[EXT_W-3] || (ncnt_q == 5'(NORM_MAX))) begin
                    data_d  = packed_w;
                    state_d = DONE;
                end else begin
                    mag_d  = mag_q << 1;
                    ncnt_d = ncnt_q + 5'd1;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            acnt_q  <= 5'd0;
            ncnt_q  <= 5'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            acnt_q  <= acnt_d;
            ncnt_q  <= ncnt_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge i_clk) begin
        ex_l_q   <= ex_l_d;
        ex_s_q   <= ex_s_d;
        mag_q    <= mag_d;
        sign_l_q <= sign_l_d;
        sign_s_q <= sign_s_d;
        sign_q   <= sign_d;
        exp_l_q  <= exp_l_d;
    end

    assign o_data = data_q;

endmodule

// File: tb/tb_fp16_sub_seq.sv
// Bench for fp16_sub_seq: directed table, randomized ops against an
// arithmetic reference model, backpressure, busy-pulse and mid-op reset.
module tb_fp16_sub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        cons_ready;
    logic [15:0] dout;

    int n_vec = 0;
    int n_err = 0;

    fp16_sub_seq dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (in_valid),
        .o_ready  (out_ready),
        .i_data_a (a),
        .i_data_b (b),
        .o_valid  (out_valid),
        .i_ready  (cons_ready),
        .o_data   (dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference: integer arithmetic on scaled significands.
    function automatic void model(input logic [15:0] xa, input logic [15:0] xb,
                                  output logic [15:0] res, output int lat);
        logic [15:0] bn, l, s;
        int el, es, d, ml, ms, sum, mag, n, c, f, g, r, st, up, e, sg;
        bn = xb ^ 16'h8000;
        if (xa[14:10] <= bn[14:10]) begin l = bn; s = xa; end
        else begin l = xa; s = bn; end
        el = int'(l[14:10]);
        es = int'(s[14:10]);
        d  = el - es;
        if (d > 23) d = 23;
        ml = (1024 + int'(l[9:0])) * 1024;
        ms = ((1024 + int'(s[9:0])) * 1024) / (1 << d);
        if (l[15]) ml = -ml;
        if (s[15]) ms = -ms;
        sum = ml + ms;
        sg  = (sum < 0) ? 1 : 0;
        mag = (sum < 0) ? -sum : sum;
        n = 0;
        c = 0;
        if (mag >= 32'h200000) c = 1;
        else while (mag < 32'h100000 && n < 20) begin mag = mag * 2; n++; end
        if (c == 1) begin
            f = (mag / 2048) % 1024; g = (mag / 2048) % 2;
            r = (mag / 1024) % 2;    st = (mag % 1024 != 0) ? 1 : 0;
        end else begin
            f = (mag / 1024) % 1024; g = (mag / 1024) % 2;
            r = (mag / 512) % 2;     st = (mag % 512 != 0) ? 1 : 0;
        end
        up  = (r == 1 && (g == 1 || st == 1)) ? 1 : 0;
        f   = (f + up) % 1024;
        e   = (((el + c - n) % 32) + 32) % 32;
        res = {sg[0], e[4:0], f[9:0]};
        lat = 3 + d + n;
    endfunction

    task automatic start_op(input logic [15:0] xa, input logic [15:0] xb);
        @(negedge clk);
        a = xa;
        b = xb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: o_valid got 0, required 1 within 100 cycles");
        end
    endtask

    task automatic consume();
        cons_ready = 1'b1;
        @(posedge clk);
        #1;
        cons_ready = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] xa, input logic [15:0] xb, input int hold,
                          output logic [15:0] res, output int lat);
        start_op(xa, xb);
        wait_valid(lat);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        res = dout;
        consume();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] res, exp_res, ra, rb;
        int          lat, exp_lat, hits;

        tbl[0] = '{16'h3C00, 16'h3800, 16'h3800, 5};
        tbl[1] = '{16'h4000, 16'hC000, 16'h4400, 3};
        tbl[2] = '{16'h3800, 16'h3C00, 16'hB800, 5};
        tbl[3] = '{16'h3C00, 16'h3C00, 16'h6C00, 23};
        tbl[4] = '{16'h7800, 16'h0400, 16'h7800, 26};

        rst = 1'b1;
        in_valid = 1'b0;
        cons_ready = 1'b0;
        a = '0;
        b = '0;
        #1;
        check("reset o_ready", 32'(out_ready), 32'd1);
        check("reset o_valid", 32'(out_valid), 32'd0);
        check("reset o_data", 32'(dout), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i].a, tbl[i].b, 0, res, lat);
            check($sformatf("table%0d data", i), 32'(res), 32'(tbl[i].exp));
            check($sformatf("table%0d latency", i), 32'(lat), 32'(tbl[i].lat));
            check($sformatf("table%0d idle after consume", i), {out_ready, out_valid}, 32'b10);
        end

        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 2 == 0) rb[14:10] = ra[14:10] + 5'($urandom_range(0, 2)) - 5'd1;
            model(ra, rb, exp_res, exp_lat);
            run_op(ra, rb, $urandom_range(0, 3), res, lat);
            check($sformatf("rand %h-%h data", ra, rb), 32'(res), 32'(exp_res));
            check($sformatf("rand %h-%h latency", ra, rb), 32'(lat), 32'(exp_lat));
        end

        start_op(16'h3C00, 16'h3800);
        wait_valid(lat);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("backpressure cycle %0d", k), {out_valid, dout}, {1'b1, 16'h3800});
        end
        consume();

        start_op(16'h4000, 16'hC000);
        @(negedge clk);
        check("busy o_ready", 32'(out_ready), 32'd0);
        in_valid = 1'b1;
        a = 16'h3C00;
        b = 16'h3800;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        check("busy result", 32'(dout), 32'h4400);
        consume();
        hits = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) hits++;
        end
        check("no extra result", 32'(hits), 32'd0);

        start_op(16'h7800, 16'h0400);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midreset o_ready", 32'(out_ready), 32'd1);
        check("midreset o_valid", 32'(out_valid), 32'd0);
        check("midreset o_data", 32'(dout), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h3800, 16'h3C00, 0, res, lat);
        check("after reset data", 32'(res), 32'hB800);
        check("after reset latency", 32'(lat), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
